stopwatch_ctrl: RTL and testbench

Control sequencer for the four-digit stopwatch datapath (ms, sec0, sec1, min0 digit counters and their dividers). Takes raw push-button inputs, synchronizes and debounces them, and runs a start/stop/resume/lap FSM. Generates the gated base tick that clocks the least-significant digit, a one-cycle clear pulse for all digits, and a display-freeze flag for lap hold. Sits between the board buttons and the digit/divider chain. It replaces the per-digit handling of start_resume/stop/reset with one central decision point.

---
 rtl/stopwatch_if.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_if
//  Purpose  : Button inputs and control outputs of the stopwatch sequencer.
//             master = board / bench side, slave = sequencer side.
//  Revision : 1.0  initial release
// ============================================================================
interface stopwatch_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       run;
  logic       tick;
  logic       clr;
  logic       freeze;
  logic [1:0] state;

  modport master (
    output btn_start, btn_stop, btn_clear, btn_lap,
    input  run, tick, clr, freeze, state
  );

  modport slave (
    input  btn_start, btn_stop, btn_clear, btn_lap,
    output run, tick, clr, freeze, state
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Central start/stop/resume/lap sequencer for the four-digit
//             stopwatch. Synchronises and debounces the push buttons, runs
//             the control FSM and produces the gated base tick, the digit
//             clear pulse and the lap display-freeze flag.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DIV = 100000,  // clk cycles per base tick (>= 2)
  parameter int DEB = 20000    // stable cycles to accept a level change (>= 1)
) (
  input  logic        clk,
  input  logic        reset,
  stopwatch_if.slave  sw
);

  localparam int PW = $clog2(DIV);
  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // Button bit order: 0 clear, 1 stop, 2 start, 3 lap (priority order).
  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    acc;
  logic [CW-1:0] cnt [4];
  logic [3:0]    press;

  logic ev_clear;
  logic ev_stop;
  logic ev_start;
  logic ev_lap;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc;
  logic          clr_q;
  logic          run_w;

  assign btn_raw = {sw.btn_lap, sw.btn_start, sw.btn_stop, sw.btn_clear};

  // Two-flop synchroniser followed by a per-button consecutive-difference debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == acc[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i] <= '0;
          acc[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press event fires in the cycle the accepted level is about to flip 0->1,
  // then only the highest-priority event of that cycle survives.
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = sync2[i] && !acc[i] && (cnt[i] == DEB_LAST);
    end
    ev_clear = press[0];
    ev_stop  = press[1] && !press[0];
    ev_start = press[2] && !(|press[1:0]);
    ev_lap   = press[3] && !(|press[2:0]);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state decision; clear wins from every state.
  always_comb begin
    state_d = state_q;
    if (ev_clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (ev_start) state_d = S_RUN;
        S_RUN:   if (ev_stop) state_d = S_PAUSE;
                 else if (ev_lap) state_d = S_LAP;
        S_PAUSE: if (ev_start) state_d = S_RUN;
        S_LAP:   if (ev_stop) state_d = S_PAUSE;
                 else if (ev_lap) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign run_w = (state_q == S_RUN) || (state_q == S_LAP);

  // Prescaler: counts only while running, holds while paused so a resume
  // keeps the partial tick, and is zeroed on the edge that enters IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (state_d == S_IDLE) begin
      presc <= '0;
    end else if (run_w) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Registered one-cycle clear pulse following a clear event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clr_q <= 1'b0;
    else       clr_q <= ev_clear;
  end

  assign sw.run    = run_w;
  assign sw.freeze = (state_q == S_LAP);
  assign sw.tick   = run_w && (presc == PRE_LAST);
  assign sw.clr    = clr_q;
  assign sw.state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Self-checking bench for stopwatch_ctrl (DIV=5, DEB=3) with a
//             behavioural reference model driven from raw button history.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;
  localparam int DIV = 5;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;  // 0 clear, 1 stop, 2 start, 3 lap

  stopwatch_if sw_if ();

  assign sw_if.btn_clear = btn[0];
  assign sw_if.btn_stop  = btn[1];
  assign sw_if.btn_start = btn[2];
  assign sw_if.btn_lap   = btn[3];

  stopwatch_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state 0 IDLE, 1 RUNNING, 2 PAUSED, 3 LAP.
  // Event index: 0 none, 1 clear, 2 stop, 3 start, 4 lap.
  int         m_state;
  int         m_p;
  bit         m_clr;
  bit   [3:0] m_acc;
  logic [3:0] hist[$];
  int         NXT [4][5] = '{'{0, 0, 0, 1, 0},
                             '{1, 0, 2, 1, 3},
                             '{2, 0, 2, 1, 2},
                             '{3, 0, 2, 3, 1}};
  int         dut_ticks;
  int         dut_clrs;

  function automatic bit exp_run();
    return (m_state == 1) || (m_state == 3);
  endfunction

  function automatic bit exp_tick();
    return exp_run() && (m_p == DIV - 1);
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_p     = 0;
    m_clr   = 0;
    m_acc   = '0;
    hist.delete();
    for (int k = 0; k < DEB + 2; k++) hist.push_back(4'b0000);
  endfunction

  // A button is accepted once its synchronised level (raw delayed by two
  // samples) has differed from the accepted level for DEB samples in a row.
  function automatic void model_step(input logic [3:0] raw);
    bit [3:0] flip;
    bit [3:0] pr;
    int       ev;
    int       n;
    int       nxt;
    bit       was_run;
    hist.push_back(raw);
    if (hist.size() > DEB + 2) void'(hist.pop_front());
    n = hist.size();
    for (int b = 0; b < 4; b++) begin
      flip[b] = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[n - 3 - j][b] == m_acc[b]) flip[b] = 1'b0;
      pr[b] = flip[b] && !m_acc[b];
    end
    ev = pr[0] ? 1 : pr[1] ? 2 : pr[2] ? 3 : pr[3] ? 4 : 0;
    was_run = exp_run();
    nxt = NXT[m_state][ev];
    if (nxt == 0)     m_p = 0;
    else if (was_run) m_p = (m_p + 1) % DIV;
    m_clr   = (ev == 1);
    m_state = nxt;
    m_acc   = m_acc ^ flip;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("run",    {7'd0, sw_if.run},    {7'd0, exp_run()});
    chk("tick",   {7'd0, sw_if.tick},   {7'd0, exp_tick()});
    chk("clr",    {7'd0, sw_if.clr},    {7'd0, m_clr});
    chk("freeze", {7'd0, sw_if.freeze}, {7'd0, (m_state == 3)});
    chk("state",  {6'd0, sw_if.state},  8'(m_state));
  endtask

  // One clock: update the model with the sampled inputs, then check just after the edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step(btn);
    #1;
    if (sw_if.tick === 1'b1) dut_ticks++;
    if (sw_if.clr === 1'b1)  dut_clrs++;
    check_outputs();
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    btn = v;
    repeat (n) cyc();
  endtask

  task automatic press(input int b, input int n);
    logic [3:0] v;
    v = '0;
    v[b] = 1'b1;
    hold(v, n);
    hold(4'b0000, 8);
  endtask

  initial begin
    reset = 1'b1;
    btn   = 4'b0000;
    model_reset();
    dut_ticks = 0;
    dut_clrs  = 0;

    // Reset state
    repeat (3) cyc();
    chk("rst_state", {6'd0, sw_if.state}, 8'd0);
    chk("rst_run",   {7'd0, sw_if.run},   8'd0);
    reset = 1'b0;
    repeat (3) cyc();

    // Start held for 10 cycles gives one start event
    press(2, 10);
    chk("start_state", {6'd0, sw_if.state}, 8'd1);
    dut_ticks = 0;
    repeat (20) cyc();
    chk("ticks_in_20", 8'(dut_ticks), 8'd4);

    // Stop once prescaler has reached 2, then stay paused
    for (int k = 0; k < DIV && m_p != 2; k++) cyc();
    press(1, 6);
    chk("stop_state", {6'd0, sw_if.state}, 8'd2);
    dut_ticks = 0;
    repeat (50) cyc();
    chk("paused_ticks", 8'(dut_ticks), 8'd0);
    press(2, 6);
    repeat (10) cyc();

    // Bouncing stop: short pulses must not be accepted
    hold(4'b0010, 1); hold(4'b0000, 2); hold(4'b0010, 2); hold(4'b0000, 1);
    hold(4'b0010, 1); hold(4'b0000, 8);
    chk("bounce_state", {6'd0, sw_if.state}, 8'd1);
    press(1, 5);
    chk("stable_stop", {6'd0, sw_if.state}, 8'd2);
    press(2, 5);

    // Lap hold and release
    press(3, 5);
    chk("lap_freeze", {7'd0, sw_if.freeze}, 8'd1);
    dut_ticks = 0;
    repeat (20) cyc();
    chk("lap_ticks_in_20", 8'(dut_ticks), 8'd4);
    press(3, 5);
    chk("lap_release", {6'd0, sw_if.state}, 8'd1);
    press(3, 5);
    press(1, 5);
    chk("lap_stop", {6'd0, sw_if.state}, 8'd2);
    press(2, 5);

    // Simultaneous clear+stop+start from RUNNING
    dut_clrs = 0;
    hold(4'b0111, 6);
    hold(4'b0000, 8);
    chk("multi_state", {6'd0, sw_if.state}, 8'd0);
    chk("multi_clr_count", 8'(dut_clrs), 8'd1);

    // Async reset mid-tick while in LAP
    press(2, 5);
    press(3, 5);
    for (int k = 0; k < DIV && !exp_tick(); k++) cyc();
    chk("pre_reset_tick", {7'd0, sw_if.tick}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_run",    {7'd0, sw_if.run},    8'd0);
    chk("areset_freeze", {7'd0, sw_if.freeze}, 8'd0);
    chk("areset_tick",   {7'd0, sw_if.tick},   8'd0);
    chk("areset_clr",    {7'd0, sw_if.clr},    8'd0);
    model_reset();
    repeat (2) cyc();
    reset = 1'b0;
    dut_clrs = 0;
    repeat (10) cyc();
    chk("post_reset_clr", 8'(dut_clrs), 8'd0);

    // Randomised button activity
    for (int s = 0; s < 150; s++) begin
      logic [3:0] v;
      v = '0;
      if ($urandom_range(0, 3) == 0) v[2] = 1'b1;
      if ($urandom_range(0, 4) == 0) v[1] = 1'b1;
      if ($urandom_range(0, 4) == 0) v[3] = 1'b1;
      if ($urandom_range(0, 14) == 0) v[0] = 1'b1;
      hold(v, $urandom_range(1, 8));
    end
    hold(4'b0000, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
